div_period_monitor: RTL and testbench

//  Receive side of the divided-clock interface. Samples a slow divided clock (div_clk) in the clk domain,

---
 rtl/div_period_monitor.sv | 158 +++++++++++++++
 tb/tb_div_period_monitor.sv | 134 +++++++++++++
 2 files changed

// File: rtl/div_period_monitor.sv
// Divided-clock health monitor: syncs div_clk, measures its period, tracks lock.
// Define DIV_MON_STICKY_ERR_EN to hold err high from the first error until reset.
module div_period_monitor #(
  parameter int RATIO  = 100,
  parameter int TOL    = 1,
  parameter int LOCK_N = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk,
  output logic             edge_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err
);

  localparam int MW = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] LO  = CNT_W'(RATIO - TOL);
  localparam logic [CNT_W-1:0] HI  = CNT_W'(RATIO + TOL);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(2 * RATIO);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  localparam logic [MW-1:0] LAST = MW'(LOCK_N - 1);
  localparam logic [MW-1:0] MONE = MW'(1);

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    LOCKED
  } state_t;

  state_t state_q, state_d;

  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [MW-1:0]    match_q, match_d;
  logic             tick_q;
  logic             pv_q, pv_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             err_ev;
  logic             rise, ok, tmo;

  assign rise = s2_q & ~s3_q;
  assign ok   = (cnt_q >= LO) && (cnt_q <= HI);
  assign tmo  = (cnt_q >= TMO);

  // Counter saturates so a dead div_clk never wraps into a fake period.
  always_comb begin
    cnt_d = cnt_q + ONE;
    if (rise) begin
      cnt_d = ONE;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    period_d = period_q;
    pv_d     = 1'b0;
    err_ev   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEAS;
          match_d = '0;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          if (ok) begin
            match_d = match_q + MONE;
            if (match_q == LAST) begin
              state_d = LOCKED;
            end
          end else begin
            match_d = '0;
            err_ev  = 1'b1;
          end
        end else if (tmo) begin
          state_d = IDLE;
          match_d = '0;
          err_ev  = 1'b1;
        end
      end
      LOCKED: begin
        if (rise) begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          if (!ok) begin
            state_d = MEAS;
            match_d = '0;
            err_ev  = 1'b1;
          end
        end else if (tmo) begin
          state_d = IDLE;
          match_d = '0;
          err_ev  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        match_d = '0;
      end
    endcase
  end

  assign locked_d = (state_d == LOCKED);

`ifdef DIV_MON_STICKY_ERR_EN
  assign err_d = err_q | err_ev;
`else
  assign err_d = err_ev;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      match_q  <= '0;
      state_q  <= IDLE;
      tick_q   <= 1'b0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_q     <= div_clk;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      match_q  <= match_d;
      state_q  <= state_d;
      tick_q   <= rise;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign edge_tick    = tick_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign err          = err_q;

endmodule

// File: tb/tb_div_period_monitor.sv
// Directed bench for div_period_monitor: lock, tolerance edges, timeout, reset.
module tb_div_period_monitor;

  localparam int CW = 16;

`ifdef DIV_MON_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          div_clk = 1'b0;
  logic          edge_tick;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          err;

  int errors = 0;
  int checks = 0;
  bit sticky_seen = 1'b0;

  div_period_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .div_clk      (div_clk),
    .edge_tick    (edge_tick),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".tick"}, 32'(edge_tick), 32'd0);
    chk({tag, ".pv"}, 32'(period_valid), 32'd0);
    chk({tag, ".per"}, 32'(period), 32'd0);
    chk({tag, ".lock"}, 32'(locked), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
  endtask

  // One div_clk period of n clk cycles starting with a rising edge now.
  // Checks the response to that rise; tmo>0 also checks a timeout at step tmo.
  task automatic period_run(input string tag, input int n, input bit pv,
                            input int per, input bit lk, input bit er,
                            input int tmo);
    div_clk = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == n / 2) div_clk = 1'b0;
      if (i == 3) begin
        chk({tag, ".tick"}, 32'(edge_tick), 32'd1);
        chk({tag, ".pv"}, 32'(period_valid), 32'(pv));
        chk({tag, ".per"}, 32'(period), 32'(per));
        chk({tag, ".lock"}, 32'(locked), 32'(lk));
        chk({tag, ".err"}, 32'(err), 32'(er | sticky_seen));
        if (er && STICKY) sticky_seen = 1'b1;
      end
      if (i == 4) begin
        chk({tag, ".tick0"}, 32'(edge_tick), 32'd0);
        chk({tag, ".pv0"}, 32'(period_valid), 32'd0);
        chk({tag, ".err0"}, 32'(err), 32'(sticky_seen));
      end
      if (tmo != 0 && i == tmo - 1) begin
        chk({tag, ".pre_tmo_lock"}, 32'(locked), 32'(lk));
        chk({tag, ".pre_tmo_err"}, 32'(err), 32'(sticky_seen));
      end
      if (tmo != 0 && i == tmo) begin
        chk({tag, ".tmo_lock"}, 32'(locked), 32'd0);
        chk({tag, ".tmo_err"}, 32'(err), 32'd1);
        if (STICKY) sticky_seen = 1'b1;
      end
      if (tmo != 0 && i == tmo + 1) begin
        chk({tag, ".post_tmo_err"}, 32'(err), 32'(sticky_seen));
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    div_clk = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    period_run("r1", 100, 1'b0, 0, 1'b0, 1'b0, 0);
    for (int k = 2; k <= 4; k++)
      period_run($sformatf("r%0d", k), 100, 1'b1, 100, 1'b0, 1'b0, 0);
    period_run("r5", 102, 1'b1, 100, 1'b1, 1'b0, 0);

    period_run("r6", 100, 1'b1, 102, 1'b0, 1'b1, 0);
    for (int k = 7; k <= 9; k++)
      period_run($sformatf("r%0d", k), 100, 1'b1, 100, 1'b0, 1'b0, 0);
    period_run("r10", 260, 1'b1, 100, 1'b1, 1'b0, 203);

    period_run("r11", 99, 1'b0, 100, 1'b0, 1'b0, 0);
    period_run("r12", 101, 1'b1, 99, 1'b0, 1'b0, 0);
    period_run("r13", 99, 1'b1, 101, 1'b0, 1'b0, 0);
    period_run("r14", 101, 1'b1, 99, 1'b0, 1'b0, 0);
    period_run("r15", 98, 1'b1, 101, 1'b1, 1'b0, 0);
    period_run("r16", 100, 1'b1, 98, 1'b0, 1'b1, 0);
    for (int k = 17; k <= 19; k++)
      period_run($sformatf("r%0d", k), 100, 1'b1, 100, 1'b0, 1'b0, 0);
    period_run("r20", 40, 1'b1, 100, 1'b1, 1'b0, 0);

    rst = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    chk_zero("midrst3");
    rst = 1'b1;
    sticky_seen = 1'b0;

    period_run("r21", 100, 1'b0, 0, 1'b0, 1'b0, 0);
    period_run("r22", 100, 1'b1, 100, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
